// File: rtl/cos_range_reduce_pkg.sv
// Shared fixed-point definitions for the cosine path (range reducer and
// Taylor core). All angle constants are Q.10 radians (1.0 = 1024).
//   W            : datapath width of angles
//   FXP_SHIFT    : fraction bits
//   TWO_PI/PI/HALF_PI : reduction constants
//   state_t      : range-reducer FSM states
package cos_fxp_pkg;
  localparam int W            = 24;
  localparam int FXP_SHIFT    = 10;
  localparam int TWO_PI       = 6434;
  localparam int PI           = 3217;
  localparam int HALF_PI      = 1608;
  // Coarse reduction walks k = COARSE_STEPS-1 .. 0 over TWO_PI<<k.
  localparam int COARSE_STEPS = 11;

  typedef enum logic [1:0] {IDLE, REDUCE, FOLD, DONE} state_t;
endpackage

// File: rtl/cos_range_reduce_if.sv
// Request/result bundle between a requester (master) and the range
// reducer (slave).
//   start      : level request, honoured only when the reducer is idle/done
//   angle_in   : signed Q.10 angle
//   angle_out  : reduced angle in [0, HALF_PI]
//   negate_out : downstream cosine must be negated
//   ready_out  : angle_out/negate_out valid
//   busy_out   : reduction in progress
interface cos_range_reduce_if
  import cos_fxp_pkg::*;
#(
  parameter int W = cos_fxp_pkg::W
);
  logic                start;
  logic signed [W-1:0] angle_in;
  logic        [W-1:0] angle_out;
  logic                negate_out;
  logic                ready_out;
  logic                busy_out;

  modport master (output start, angle_in,
                  input  angle_out, negate_out, ready_out, busy_out);
  modport slave  (input  start, angle_in,
                  output angle_out, negate_out, ready_out, busy_out);
endinterface

// File: rtl/cos_range_reduce_fold.sv
// cos_quadrant_fold: combinational quadrant fold of an angle already in
// [0, TWO_PI) down to [0, HALF_PI], using cos(2pi-x)=cos(x) and
// cos(pi-x)=-cos(x).
//   r      : input angle, unsigned, < TWO_PI_C
//   angle  : folded angle in [0, HALF_PI_C]
//   negate : 1 when the cosine of angle must be negated
module cos_quadrant_fold
  import cos_fxp_pkg::*;
#(
  parameter int           W         = cos_fxp_pkg::W,
  parameter logic [W-1:0] TWO_PI_C  = W'(cos_fxp_pkg::TWO_PI),
  parameter logic [W-1:0] PI_C      = W'(cos_fxp_pkg::PI),
  parameter logic [W-1:0] HALF_PI_C = W'(cos_fxp_pkg::HALF_PI)
) (
  input  logic [W-1:0] r,
  output logic [W-1:0] angle,
  output logic         negate
);
  logic [W-1:0] r_half;

  always_comb begin
    // Upper half mirrors onto [0, PI]; r==PI stays put.
    r_half = (r > PI_C) ? (TWO_PI_C - r) : r;
    if (r_half > HALF_PI_C) begin
      angle  = PI_C - r_half;
      negate = 1'b1;
    end else begin
      angle  = r_half;
      negate = 1'b0;
    end
  end
endmodule

// File: rtl/cos_range_reduce.sv
// cos_range_reduce: reduces a signed Q.10 angle to [0, HALF_PI] plus a
// negate flag for the Taylor cosine core.
//   clock      : rising-edge clock
//   reset      : async active-low reset
//   bus        : cos_range_reduce_if.slave (start/angle_in in,
//                angle_out/negate_out/ready_out/busy_out out)
// Build option COS_RANGE_REDUCE_COARSE_EN: fixed 11-cycle binary
// reduction (TWO_PI<<k, k=10..0) instead of one TWO_PI per cycle.
// Results are identical in both builds; only latency differs.
module cos_range_reduce
  import cos_fxp_pkg::*;
#(
  parameter int W         = 24,
  parameter int FXP_SHIFT = 10
) (
  input  logic              clock,
  input  logic              reset,
  cos_range_reduce_if.slave bus
);
  // Package constants are Q.10; rescale if a different fraction width is used.
  localparam int Q_ADJ = FXP_SHIFT - cos_fxp_pkg::FXP_SHIFT;
  localparam int Q_UP  = (Q_ADJ > 0) ? Q_ADJ : 0;
  localparam int Q_DN  = (Q_ADJ < 0) ? -Q_ADJ : 0;
  localparam logic [W-1:0] K_TWO_PI  = W'((TWO_PI  << Q_UP) >> Q_DN);
  localparam logic [W-1:0] K_PI      = W'((PI      << Q_UP) >> Q_DN);
  localparam logic [W-1:0] K_HALF_PI = W'((HALF_PI << Q_UP) >> Q_DN);

  state_t       state_q, state_d;
  logic [W-1:0] r_q, r_d;
  logic [W-1:0] angle_q, angle_d;
  logic         neg_q, neg_d;
  logic [W-1:0] abs_in;
  logic [W-1:0] fold_angle;
  logic         fold_neg;

`ifdef COS_RANGE_REDUCE_COARSE_EN
  localparam int CW = W + COARSE_STEPS;
  logic [3:0]    k_q, k_d;
  logic [CW-1:0] sub_w;
  assign sub_w = CW'(K_TWO_PI) << k_q;
`endif

  // Two's-complement magnitude; -2^(W-1) maps to 2^(W-1) as unsigned.
  assign abs_in = bus.angle_in[W-1] ? (~bus.angle_in + 1'b1) : bus.angle_in;

  cos_quadrant_fold #(
    .W        (W),
    .TWO_PI_C (K_TWO_PI),
    .PI_C     (K_PI),
    .HALF_PI_C(K_HALF_PI)
  ) u_fold (
    .r     (r_q),
    .angle (fold_angle),
    .negate(fold_neg)
  );

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (bus.start) state_d = REDUCE;
`ifdef COS_RANGE_REDUCE_COARSE_EN
      REDUCE: if (k_q == 4'd0) state_d = FOLD;
`else
      REDUCE: if (r_q < K_TWO_PI) state_d = FOLD;
`endif
      FOLD:   state_d = DONE;
      DONE:   if (!bus.start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.busy_out  = 1'b0;
    bus.ready_out = 1'b0;
    case (state_q)
      REDUCE, FOLD: bus.busy_out  = 1'b1;
      DONE:         bus.ready_out = 1'b1;
      default: ;
    endcase
  end

  assign bus.angle_out  = angle_q;
  assign bus.negate_out = neg_q;

  // Datapath next state
  always_comb begin
    r_d     = r_q;
    angle_d = angle_q;
    neg_d   = neg_q;
`ifdef COS_RANGE_REDUCE_COARSE_EN
    k_d     = k_q;
`endif
    case (state_q)
      IDLE: if (bus.start) begin
        r_d = abs_in;
`ifdef COS_RANGE_REDUCE_COARSE_EN
        k_d = 4'(COARSE_STEPS - 1);
`endif
      end
      REDUCE: begin
`ifdef COS_RANGE_REDUCE_COARSE_EN
        // Restoring division by TWO_PI, one quotient bit per cycle.
        if (CW'(r_q) >= sub_w) r_d = r_q - sub_w[W-1:0];
        if (k_q != 4'd0) k_d = k_q - 4'd1;
`else
        if (r_q >= K_TWO_PI) r_d = r_q - K_TWO_PI;
`endif
      end
      FOLD: begin
        angle_d = fold_angle;
        neg_d   = fold_neg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q     <= '0;
      angle_q <= '0;
      neg_q   <= 1'b0;
`ifdef COS_RANGE_REDUCE_COARSE_EN
      k_q     <= '0;
`endif
    end else begin
      r_q     <= r_d;
      angle_q <= angle_d;
      neg_q   <= neg_d;
`ifdef COS_RANGE_REDUCE_COARSE_EN
      k_q     <= k_d;
`endif
    end
  end
endmodule

// File: doc/cos_range_reduce.md
COS_RANGE_REDUCE -- requirements
Module: cos_range_reduce

Interface
REQ-001 SHALL have parameter W, default 24, meaning datapath width in bits for angle_in and angle_out.
REQ-002 SHALL have parameter FXP_SHIFT, default 10, meaning fraction bits (Q.10, 1.0 = 1024).
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, level request; sampled only in IDLE and DONE.
REQ-006 SHALL have port angle_in, input, W, signed angle in radians, Q.10.
REQ-007 SHALL have port angle_out, output, W, reduced angle in [0, HALF_PI], Q.10, for the downstream Taylor cosine core.
REQ-008 SHALL have port negate_out, output, 1, where 1 means the downstream cosine result must be negated.
REQ-009 SHALL have port ready_out, output, 1, where 1 means angle_out and negate_out are valid.
REQ-010 SHALL have port busy_out, output, 1, which is 1 in REDUCE and FOLD.

Function
REQ-011 SHALL use constants TWO_PI=6434, PI=3217 and HALF_PI=1608, all Q.10.
REQ-012 SHALL use FSM states IDLE, REDUCE, FOLD and DONE.
REQ-013 In IDLE with start=1, SHALL latch r <= |angle_in| as W-bit unsigned and enter REDUCE; |-2^(W-1)| = 2^(W-1) SHALL be representable without overflow.
REQ-014 In REDUCE (coarse disabled), SHALL compute r -= TWO_PI and stay in REDUCE if r >= TWO_PI, else enter FOLD.
REQ-015 In FOLD, SHALL apply in order: if r > PI then r = TWO_PI - r; then if r > HALF_PI then r = PI - r and negate = 1, else negate = 0.
REQ-016 In FOLD, SHALL register angle_out and negate_out, set ready_out=1, and enter DONE.
REQ-017 Boundaries: r==PI SHALL give angle_out 0 and negate 1; r==HALF_PI SHALL give angle_out 1608 and negate 0.
REQ-018 In DONE, SHALL hold ready_out, angle_out and negate_out while start=1.
REQ-019 In DONE with start=0, SHALL clear ready_out and enter IDLE; outputs SHALL retain their last values.
REQ-020 Latency (coarse disabled), with E0 the edge at which start is sampled: ready_out SHALL rise after edge E(N+2), where N = floor(|angle_in|/6434).
REQ-021 SHALL ignore start and angle_in changes in REDUCE and FOLD.

Reset
REQ-022 On reset=0, SHALL asynchronously force state IDLE, ready_out=0, angle_out=0, negate_out=0, busy_out=0 and r=0.
REQ-023 Reset mid-operation SHALL abort with no output update.
REQ-024 After release, SHALL sample start no earlier than the first rising edge.

Configuration
REQ-025 With COS_RANGE_REDUCE_COARSE_EN defined, REDUCE SHALL run exactly 11 cycles with k = 10 down to 0, doing r -= TWO_PI<<k when r >= TWO_PI<<k; ready_out SHALL then rise after E12 for every input.
REQ-026 Without COS_RANGE_REDUCE_COARSE_EN, REDUCE SHALL use the single-step subtraction of REQ-014.
REQ-027 angle_out and negate_out SHALL be bit-identical in both builds.

Structure
REQ-028 Package cos_fxp_pkg SHALL hold W, FXP_SHIFT, PI, HALF_PI, TWO_PI and the FSM state enum; it is shared with the Taylor cosine core.
REQ-029 The REQ-015 fold SHALL be implemented as combinational sub-module cos_quadrant_fold (inputs r; outputs angle, negate).

Verification
REQ-030 Bench SHALL cover: angle_in 0 -> angle_out 0, negate 0, ready after E2 (fine build) or E12 (coarse build).
REQ-031 Bench SHALL cover: angle_in 3217 -> angle_out 0, negate 1; angle_in 2000 -> angle_out 1217, negate 1.
REQ-032 Bench SHALL cover: angle_in -1000 -> angle_out 1000, negate 0; angle_in 7000 -> angle_out 566, negate 0, ready after E3 (fine build).
REQ-033 Bench SHALL cover: angle_in -8388608 -> angle_out 1328, negate 0, ready after E1305 (fine build) or E12 (coarse build).
REQ-034 Bench SHALL cover: start held high after ready -> outputs stable and no restart; start dropped -> ready 0 next edge, then a new request accepted.
REQ-035 Bench SHALL cover: reset=0 asserted mid-REDUCE -> all outputs 0 immediately; after release with start=1 -> fresh computation completes correctly.
